// File: rtl/delay_tap_capture.sv
// Delay-line tap capture: fires 2^LOG2_SHOTS launch edges into a tapped delay line,
// counts how far each edge travelled and reports the sum, average and health flags.
module delay_tap_capture #(
    parameter int TAPS        = 16,
    parameter int LOG2_SHOTS  = 2,
    parameter int SAMPLE_WAIT = 3,
    parameter int RELAX_MAX   = 15
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [TAPS-1:0]                       taps,
    output logic                                  launch,
    output logic                                  busy,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [$clog2(TAPS+1)+LOG2_SHOTS-1:0]  res_sum,
    output logic [$clog2(TAPS+1)-1:0]             res_avg,
    output logic                                  res_bubble,
    output logic                                  res_stuck
);
    localparam int CW   = $clog2(TAPS + 1);
    localparam int SW   = CW + LOG2_SHOTS;
    localparam int TMAX = (RELAX_MAX > SAMPLE_WAIT) ? RELAX_MAX : SAMPLE_WAIT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int NW   = LOG2_SHOTS + 1;
    localparam logic [NW-1:0] SHOTS = NW'(1 << LOG2_SHOTS);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_RELAX, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TAPS-1:0] taps_m_q, taps_s_q;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NW-1:0]   shots_q, shots_d;
    logic [SW-1:0]   acc_q, acc_d;
    logic            bubble_q, bubble_d, stuck_q, stuck_d;
    logic            launch_q, launch_d, busy_q, busy_d, valid_q, valid_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [CW-1:0]   avg_q, avg_d;
    logic            res_bubble_q, res_bubble_d, res_stuck_q, res_stuck_d;

    // run_ones[i] is set while taps_s bits 0..i-1 are all ones.
    logic [TAPS:0]   run_ones;
    logic [CW-1:0]   shot_cnt;
    logic            shot_bubble;
    logic            relax_leave;

    assign run_ones[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_run
            assign run_ones[gi+1] = run_ones[gi] & taps_s_q[gi];
        end
    endgenerate

    always_comb begin
        shot_cnt = '0;
        for (int i = 1; i <= TAPS; i++) begin
            shot_cnt = shot_cnt + CW'(run_ones[i]);
        end
        shot_bubble = |(taps_s_q & ~run_ones[TAPS:1]);
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        shots_d      = shots_q;
        acc_d        = acc_q;
        bubble_d     = bubble_q;
        stuck_d      = stuck_q;
        sum_d        = sum_q;
        avg_d        = avg_q;
        res_bubble_d = res_bubble_q;
        res_stuck_d  = res_stuck_q;
        relax_leave  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LAUNCH;
                    acc_d    = '0;
                    shots_d  = '0;
                    bubble_d = 1'b0;
                    stuck_d  = 1'b0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                if (timer_q == TW'(SAMPLE_WAIT - 1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CAPTURE: begin
                acc_d    = acc_q + SW'(shot_cnt);
                shots_d  = shots_q + NW'(1);
                bubble_d = bubble_q | shot_bubble;
                timer_d  = '0;
                state_d  = S_RELAX;
            end
            S_RELAX: begin
                if (taps_s_q == '0) begin
                    relax_leave = 1'b1;
                end else if (timer_q == TW'(RELAX_MAX - 1)) begin
                    relax_leave = 1'b1;
                    stuck_d     = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                if (relax_leave) begin
                    if (shots_q == SHOTS) begin
                        // Results are latched only here so they hold between measurements.
                        state_d      = S_DONE;
                        sum_d        = acc_q;
                        avg_d        = CW'(acc_q >> LOG2_SHOTS);
                        res_bubble_d = bubble_q;
                        res_stuck_d  = stuck_d;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        launch_d = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_CAPTURE);
        busy_d   = (state_d != S_IDLE);
        valid_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            taps_m_q     <= '0;
            taps_s_q     <= '0;
            timer_q      <= '0;
            shots_q      <= '0;
            acc_q        <= '0;
            bubble_q     <= 1'b0;
            stuck_q      <= 1'b0;
            launch_q     <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            sum_q        <= '0;
            avg_q        <= '0;
            res_bubble_q <= 1'b0;
            res_stuck_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            taps_m_q     <= taps;
            taps_s_q     <= taps_m_q;
            timer_q      <= timer_d;
            shots_q      <= shots_d;
            acc_q        <= acc_d;
            bubble_q     <= bubble_d;
            stuck_q      <= stuck_d;
            launch_q     <= launch_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            sum_q        <= sum_d;
            avg_q        <= avg_d;
            res_bubble_q <= res_bubble_d;
            res_stuck_q  <= res_stuck_d;
        end
    end

    assign launch     = launch_q;
    assign busy       = busy_q;
    assign res_valid  = valid_q;
    assign res_sum    = sum_q;
    assign res_avg    = avg_q;
    assign res_bubble = res_bubble_q;
    assign res_stuck  = res_stuck_q;
endmodule

// File: tb/tb_delay_tap_capture.sv
// Scoreboard bench for delay_tap_capture: stimulus pushes model results, a negedge
// monitor checks every cycle the DUT presents a result, plus launch/relax timing.
`timescale 1ns/1ps
module tb_delay_tap_capture;
    localparam int TAPS        = 16;
    localparam int LOG2_SHOTS  = 2;
    localparam int SAMPLE_WAIT = 3;
    localparam int RELAX_MAX   = 15;
    localparam int CW          = $clog2(TAPS + 1);
    localparam int SW          = CW + LOG2_SHOTS;
    localparam int SHOTS       = 1 << LOG2_SHOTS;
    localparam int M_LINE = 0, M_PAT = 1, M_STUCK = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            res_ready = 1'b0;
    logic [TAPS-1:0] taps = '0;
    logic            launch, busy, res_valid, res_bubble, res_stuck;
    logic [SW-1:0]   res_sum;
    logic [CW-1:0]   res_avg;

    delay_tap_capture #(
        .TAPS(TAPS), .LOG2_SHOTS(LOG2_SHOTS), .SAMPLE_WAIT(SAMPLE_WAIT), .RELAX_MAX(RELAX_MAX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .taps(taps), .launch(launch), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_avg(res_avg),
        .res_bubble(res_bubble), .res_stuck(res_stuck)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int avg;
        bit bubble;
        bit stuck;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            cur;
    exp_t            last;
    int              checks = 0;
    int              failures = 0;
    int              mode = M_PAT;
    logic [TAPS-1:0] pats [SHOTS];
    logic [TAPS-1:0] idle_val = '0;
    bit              suppress = 1'b0;
    int              n_results = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected result straight from the counting rules, one shot at a time.
    function automatic exp_t model();
        exp_t            e;
        int              sum;
        int              c;
        bit              bub;
        logic [TAPS-1:0] p;
        sum = 0;
        bub = 1'b0;
        for (int s = 0; s < SHOTS; s++) begin
            c = 0;
            if (mode == M_LINE) begin
                // The line gains a tap on each falling clock edge with launch high;
                // after the two-flop synchronizer, capture sees SAMPLE_WAIT taps.
                c = SAMPLE_WAIT;
            end else begin
                p = pats[s];
                while (c < TAPS && p[c]) c++;
                if (c < TAPS && (p >> c) != '0) bub = 1'b1;
            end
            sum += c;
        end
        e.sum    = sum;
        e.avg    = sum / SHOTS;
        e.bubble = bub;
        e.stuck  = (mode == M_STUCK);
        return e;
    endfunction

    // Delay-line / pattern driver: taps change on the falling edge, asynchronous to capture.
    logic [TAPS-1:0] line = '0;
    int              shot_idx = 0;
    logic            launch_prev = 1'b0;
    always @(negedge clk) begin
        if (!busy) shot_idx = 0;
        else if (launch_prev && !launch) shot_idx++;
        if (mode == M_LINE) begin
            line = launch ? {line[TAPS-2:0], 1'b1} : '0;
            taps = line;
        end else begin
            taps = launch ? pats[shot_idx % SHOTS] : idle_val;
        end
        launch_prev = launch;
    end

    // Monitor: result scoreboard, post-handshake state, launch width and relax length.
    int run_len = 0;
    int gap_len = 0;
    bit gap_active = 1'b0;
    int post = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (launch) begin
                if (gap_active && mode == M_STUCK && !suppress)
                    check("relax_len", gap_len, RELAX_MAX);
                gap_active = 1'b0;
                gap_len = 0;
                run_len++;
            end else begin
                if (run_len != 0) begin
                    if (!suppress) check("launch_len", run_len, SAMPLE_WAIT + 2);
                    gap_active = 1'b1;
                    gap_len = 0;
                end
                run_len = 0;
                if (gap_active) gap_len++;
                if (!busy) gap_active = 1'b0;
            end

            if (post > 0) begin
                check("post_busy", longint'(busy), 0);
                if (post == 2) begin
                    check("post_valid", longint'(res_valid), 0);
                    check("held_sum", longint'(res_sum), last.sum);
                    check("held_avg", longint'(res_avg), last.avg);
                end
                post--;
            end

            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    cur = exp_q[0];
                    check("res_sum", longint'(res_sum), cur.sum);
                    check("res_avg", longint'(res_avg), cur.avg);
                    check("res_bubble", longint'(res_bubble), longint'(cur.bubble));
                    check("res_stuck", longint'(res_stuck), longint'(cur.stuck));
                    if (res_ready) begin
                        last = exp_q.pop_front();
                        n_results++;
                        post = 2;
                        $display("result %0d: sum=%0d avg=%0d bubble=%0b stuck=%0b (model sum=%0d avg=%0d)",
                                 n_results, res_sum, res_avg, res_bubble, res_stuck, last.sum, last.avg);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pats(input logic [TAPS-1:0] p);
        for (int s = 0; s < SHOTS; s++) pats[s] = p;
    endtask

    task automatic do_measure(input int ready_delay, input bit mid_start,
                              input bit done_start, input bit hs_start);
        int i;
        exp_q.push_back(model());
        start = 1'b1;
        tick();
        start = 1'b0;
        suppress = 1'b0;
        check("busy_after_start", longint'(busy), 1);
        check("launch_after_start", longint'(launch), 1);
        for (i = 0; i < 1000 && !res_valid; i++) begin
            start = mid_start && (i == 6);
            tick();
        end
        start = 1'b0;
        if (!res_valid) check("result_timeout", 0, 1);
        for (int k = 0; k < ready_delay; k++) begin
            start = done_start && (k == ready_delay / 2);
            tick();
        end
        start = hs_start;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        repeat (3) tick();
    endtask

    task automatic reset_mid_wait();
        int   rises;
        logic prev;
        mode = M_PAT;
        set_pats(16'h00FF);
        suppress = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (launch && !prev) rises++;
            prev = launch;
            if (rises == 2) break;
            tick();
        end
        check("second_launch_seen", rises, 2);
        tick();
        check("in_wait_launch", longint'(launch), 1);
        rst = 1'b1;
        tick();
        check("rst_launch", longint'(launch), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_valid", longint'(res_valid), 0);
        check("rst_sum", longint'(res_sum), 0);
        check("rst_avg", longint'(res_avg), 0);
        check("rst_flags", longint'({res_bubble, res_stuck}), 0);
        rst = 1'b0;
    endtask

    initial begin
        logic [TAPS-1:0] p;
        set_pats('0);
        rst = 1'b1;
        repeat (3) tick();
        check("reset_launch", longint'(launch), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_valid", longint'(res_valid), 0);
        check("reset_sum", longint'(res_sum), 0);
        check("reset_avg", longint'(res_avg), 0);
        check("reset_flags", longint'({res_bubble, res_stuck}), 0);
        rst = 1'b0;

        // Start on the very first edge after reset, delay-line model.
        mode = M_LINE;
        do_measure(0, 1'b0, 1'b0, 1'b0);

        mode = M_PAT;
        set_pats(16'h00FF);
        do_measure(2, 1'b1, 1'b0, 1'b0);

        set_pats(16'h00F7);
        do_measure(1, 1'b0, 1'b0, 1'b1);

        mode = M_STUCK;
        idle_val = '1;
        set_pats('1);
        do_measure(0, 1'b0, 1'b0, 1'b0);
        idle_val = '0;

        // Consumer stalls for 10 cycles with a start pulse during DONE.
        mode = M_PAT;
        pats[0] = 16'h003F; pats[1] = 16'h007F; pats[2] = 16'h001F; pats[3] = 16'h0FFF;
        do_measure(10, 1'b0, 1'b1, 1'b0);

        reset_mid_wait();
        set_pats(16'h00FF);
        do_measure(0, 1'b0, 1'b0, 1'b0);

        for (int m = 0; m < 8; m++) begin
            for (int s = 0; s < SHOTS; s++) begin
                p = '0;
                for (int j = 0; j < int'($urandom_range(0, TAPS)); j++) p[j] = 1'b1;
                if ($urandom_range(0, 2) == 0) p[$urandom_range(0, TAPS - 1)] ^= 1'b1;
                pats[s] = p;
            end
            do_measure(int'($urandom_range(0, 4)), m[0], 1'b0, m[1]);
        end

        repeat (5) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/delay_tap_capture.md
DELAY_TAP_CAPTURE -- requirements
Module: delay_tap_capture

Interface
- REQ-001: Parameter TAPS, default 16: width of the thermometer tap bus from the delay line.
- REQ-002: Parameter LOG2_SHOTS, default 2: the block averages 2^LOG2_SHOTS launches per measurement.
- REQ-003: Parameter SAMPLE_WAIT, default 3: clock cycles between the launch edge and tap capture (range 1..15).
- REQ-004: Parameter RELAX_MAX, default 15: maximum clock cycles spent waiting for the taps to clear.
- REQ-005: clk, input, 1: single clock; all state updates on the rising edge.
- REQ-006: rst, input, 1: synchronous reset, active-high.
- REQ-007: start, input, 1: request one measurement; sampled only in IDLE.
- REQ-008: taps, input, TAPS: asynchronous thermometer output of the delay line; bit0 is nearest the launch point.
- REQ-009: launch, output, 1: registered edge driven into the delay-line input.
- REQ-010: busy, output, 1: high in every state except IDLE.
- REQ-011: res_valid, output, 1: result available.
- REQ-012: res_ready, input, 1: consumer accepts the result.
- REQ-013: res_sum, output, clog2(TAPS+1)+LOG2_SHOTS: sum of the per-shot counts.
- REQ-014: res_avg, output, clog2(TAPS+1): res_sum shifted right by LOG2_SHOTS, truncated.
- REQ-015: res_bubble, output, 1: at least one shot was non-monotonic.
- REQ-016: res_stuck, output, 1: at least one relax phase timed out.

Function
- REQ-017: taps shall pass through a two-flop synchronizer (taps_s) every cycle, independent of state.
- REQ-018: FSM states are IDLE, LAUNCH, WAIT, CAPTURE, RELAX and DONE.
- REQ-019: IDLE shall move to LAUNCH on the cycle after start=1, clearing the accumulator, shot counter and flags.
- REQ-020: LAUNCH shall last 1 cycle, and launch shall be 1 in LAUNCH, WAIT and CAPTURE and 0 otherwise.
- REQ-021: WAIT shall last exactly SAMPLE_WAIT cycles, then go to CAPTURE.
- REQ-022: CAPTURE (1 cycle) shall compute the shot count as the number of consecutive 1s in taps_s starting at bit0 (0..TAPS).
- REQ-023: CAPTURE shall add the shot count to the accumulator.
- REQ-024: CAPTURE shall set the bubble flag if any 1 exists above the first 0.
- REQ-025: RELAX shall wait until taps_s==0, or until RELAX_MAX cycles have elapsed; a timeout sets the stuck flag.
- REQ-026: On leaving RELAX, the FSM shall go to LAUNCH if shots remain, else to DONE.
- REQ-027: The accumulator width shall not overflow: TAPS*2^LOG2_SHOTS fits by construction.
- REQ-028: DONE shall hold res_valid=1 and keep all result outputs stable until res_valid&&res_ready.
- REQ-029: The cycle after the DONE handshake, the FSM shall be in IDLE with res_valid=0 and busy=0.
- REQ-030: start while busy shall be ignored, and nothing is queued.
- REQ-031: start in the same cycle as the DONE handshake shall be ignored.
- REQ-032: Result registers shall update only on entry to DONE; their values between measurements are held from the previous measurement.

Reset
- REQ-033: rst=1 at any edge, including mid-measurement, shall force IDLE.
- REQ-034: Reset values: launch=0, busy=0, res_valid=0, res_sum=0, res_avg=0, res_bubble=0, res_stuck=0, synchronizer=0, and counters=0.
- REQ-035: The first start shall be honoured on the first edge after rst falls.

Verification
- REQ-036: Bench model where taps = launch spread one tap per cycle (asynchronous w.r.t. capture), TAPS=16, SAMPLE_WAIT=3 -> every shot is identical, res_avg equals the tap count reached at capture, res_sum=4*res_avg, and bubble=stuck=0.
- REQ-037: taps forced 16'h00FF during capture and 0 otherwise -> res_sum=32, res_avg=8, res_bubble=0.
- REQ-038: taps forced 16'h00F7 (bubble at bit3) during capture -> per-shot count=3, res_sum=12, res_avg=3, res_bubble=1.
- REQ-039: taps stuck at 16'hFFFF -> res_sum=64, res_avg=16, and res_stuck=1 with each RELAX lasting exactly RELAX_MAX cycles.
- REQ-040: res_ready held 0 for 10 cycles in DONE -> res_valid and the results stay stable; a start pulse during that time is ignored; after res_ready=1 the FSM is IDLE the next cycle.
- REQ-041: rst asserted during WAIT of the 2nd shot -> the next cycle launch=0, busy=0 and all results=0; a following start yields a normal full 4-shot measurement.
